// File: rtl/block_arb_pkg.sv
// Shared types, defaults and the round-robin pick function for block_arbiter.
package block_arb_pkg;

  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;
  localparam int unsigned MAX_NREQ     = 16;
  localparam int unsigned MAX_PTR_W    = 4;
  localparam int unsigned SUM_W        = MAX_PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_PTR_W-1:0] idx;
  } rr_pick_t;

  // First asserted req at or after ptr, wrapping n-1 -> 0; ptr must be < n.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0]  req,
                                       input logic [MAX_PTR_W-1:0] ptr,
                                       input int unsigned          n);
    rr_pick_t         r;
    logic [SUM_W-1:0] i;
    r = '0;
    i = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      if (!r.valid && (k < n)) begin
        i = {1'b0, ptr} + SUM_W'(k);
        if (i >= SUM_W'(n)) i = i - SUM_W'(n);
        if (req[i[MAX_PTR_W-1:0]]) begin
          r.valid = 1'b1;
          r.idx   = i[MAX_PTR_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/block_arb_rr.sv
// Combinational round-robin picker: req + pointer -> winner index and valid.
module block_arb_rr
  import block_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_NREQ'(req), MAX_PTR_W'(ptr), NREQ);
    idx   = PTR_W'(pick.idx);
    valid = pick.valid;
  end

endmodule

// File: rtl/block_arbiter.sv
// Round-robin owner arbiter in front of one shared `block` unit.
// Optional hold-time preemption is enabled by defining BLOCK_ARBITER_TIMEOUT_EN.
module block_arbiter
  import block_arb_pkg::*;
#(
  parameter  int unsigned NREQ     = DEF_NREQ,
  parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
  localparam int unsigned PTR_W    = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_in1,
  input  logic [NREQ-1:0] req_in2,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] preempt,
  output logic            busy,
  output logic            blk_in1,
  output logic            blk_in2,
  input  logic            blk_out1,
  input  logic            blk_out2,
  output logic            rsp_out1,
  output logic            rsp_out2
);

  if ((NREQ < 2) || (NREQ > MAX_NREQ) || (MAX_HOLD < 2)) begin : g_param_check
    $error("block_arbiter: NREQ must be 2..16 and MAX_HOLD >= 2");
  end

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [PTR_W-1:0]  own, own_nxt, own_inc;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              timeout;
  logic [NREQ-1:0]   gnt_nxt;
  logic              busy_nxt, blk_in1_nxt, blk_in2_nxt;

  block_arb_rr #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_inc  = (own == PTR_W'(NREQ - 1)) ? '0 : own + PTR_W'(1);
  assign rsp_out1 = blk_out1;
  assign rsp_out2 = blk_out2;

`ifdef BLOCK_ARBITER_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  // Decoded from live req so a release on the final owned cycle wins over preemption.
  assign timeout = (state == OWN) && req[own] && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign preempt = timeout ? (NREQ'(1) << own) : '0;

  always_comb begin
    hold_nxt = '0;
    if ((state == OWN) && (state_nxt == OWN)) hold_nxt = hold_cnt + HOLD_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_cnt <= '0;
    else        hold_cnt <= hold_nxt;
  end
`else
  assign timeout = 1'b0;
  assign preempt = '0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    own_nxt     = own;
    gnt_nxt     = '0;
    busy_nxt    = 1'b0;
    blk_in1_nxt = 1'b0;
    blk_in2_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_nxt = OWN;
          own_nxt   = pick_idx;
          gnt_nxt   = NREQ'(1) << pick_idx;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        if (!req[own] || timeout) begin
          state_nxt = GAP;
          ptr_nxt   = own_inc;
        end else begin
          gnt_nxt     = gnt;
          busy_nxt    = 1'b1;
          blk_in1_nxt = req_in1[own];
          blk_in2_nxt = req_in2[own];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      blk_in1 <= 1'b0;
      blk_in2 <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      own     <= own_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      blk_in1 <= blk_in1_nxt;
      blk_in2 <= blk_in2_nxt;
    end
  end

  gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));

endmodule

// File: tb/tb_block_arbiter.sv
// Directed-vector bench for block_arbiter; expectations queued per cycle, checked by a monitor.
module tb_block_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req_in1, req_in2;
  logic [3:0] gnt, preempt;
  logic       busy, blk_in1, blk_in2;
  logic       blk_out1, blk_out2, rsp_out1, rsp_out2;

  always #5 clk = ~clk;

  block_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_in1  (req_in1),
    .req_in2  (req_in2),
    .gnt      (gnt),
    .preempt  (preempt),
    .busy     (busy),
    .blk_in1  (blk_in1),
    .blk_in2  (blk_in2),
    .blk_out1 (blk_out1),
    .blk_out2 (blk_out2),
    .rsp_out1 (rsp_out1),
    .rsp_out2 (rsp_out2)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       busy;
    logic       b1;
    logic       b2;
    logic [3:0] pre;
    logic [1:0] rsp;
  } obs_t;

  typedef struct {
    int   cyc;
    int   id;
    obs_t exp;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_id  = 0;
  bit   done  = 1'b0;

  localparam int unsigned WATCHDOG_CYC = 2000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs just after the edge and queue the outputs expected this cycle.
  task automatic apply(input logic rst, input logic [3:0] r, input logic [3:0] i1,
                       input logic [3:0] i2, input logic [3:0] g, input logic bz,
                       input logic e1, input logic e2, input logic [3:0] pr);
    exp_t e;
    tick();
    reset    = rst;
    req      = r;
    req_in1  = i1;
    req_in2  = i2;
    blk_out1 = cyc[0];
    blk_out2 = cyc[1];
    e.cyc = cyc;
    e.id  = n_id;
    e.exp = {g, bz, e1, e2, pr, blk_out1, blk_out2};
    n_id++;
    q.push_back(e);
  endtask

  // Reset-state check: while reset is low every registered output must already be clear.
  task automatic check_reset_state(input string tag);
    #1;
    n_vec++;
    if ((gnt !== 4'b0000) || (preempt !== 4'b0000) || (busy !== 1'b0) ||
        (blk_in1 !== 1'b0) || (blk_in2 !== 1'b0)) begin
      n_bad++;
      $display("FAIL reset-state %s cyc%0d: gnt=%b pre=%b busy=%b blk=%b%b",
               tag, cyc, gnt, preempt, busy, blk_in1, blk_in2);
    end
  endtask

  // Scoreboard monitor: anything still queued for this or an earlier cycle is compared now.
  always @(negedge clk) begin
    obs_t act;
    act = {gnt, busy, blk_in1, blk_in2, preempt, rsp_out1, rsp_out2};
    while ((q.size() > 0) && (q[0].cyc <= cyc)) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if ((e.cyc != cyc) || (act !== e.exp)) begin
        n_bad++;
        $display("FAIL vec%0d cyc%0d: got gnt=%b busy=%b blk=%b%b pre=%b rsp=%b%b, want gnt=%b busy=%b blk=%b%b pre=%b rsp=%b (due cyc%0d)",
                 e.id, cyc, gnt, busy, blk_in1, blk_in2, preempt, rsp_out1, rsp_out2,
                 e.exp.gnt, e.exp.busy, e.exp.b1, e.exp.b2, e.exp.pre, e.exp.rsp, e.cyc);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded number of cycles.
  initial begin
    repeat (WATCHDOG_CYC) @(posedge clk);
    if (!done) begin
      n_bad++;
      $display("FAIL watchdog: stimulus not finished after %0d cycles", WATCHDOG_CYC);
      $finish;
    end
  end

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_in1  = '0;
    req_in2  = '0;
    blk_out1 = 1'b0;
    blk_out2 = 1'b0;

    check_reset_state("power-on");

    // reset, then a mid-ownership reset must clear outputs within the cycle
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000);
    apply(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_reset_state("mid-ownership");
    apply(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // wrap: ptr=3 with only req[0]; next pointer becomes 1, not 0
    apply(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // single requester 1: data lags one cycle, non-owner bits ignored
    apply(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
    apply(1'b1, 4'b0010, 4'b1000, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0000);
    apply(1'b1, 4'b0010, 4'b1101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // round robin from ptr=0 with all four requesting, 3 owned cycles each
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000);
    apply(1'b1, 4'b1110, 4'b0101, 4'b1010, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
    apply(1'b1, 4'b1101, 4'b0101, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000);
    apply(1'b1, 4'b1011, 4'b0101, 4'b1010, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000);
    apply(1'b1, 4'b0111, 4'b0101, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

`ifdef BLOCK_ARBITER_TIMEOUT_EN
    // ptr=1, req[2] and req[3] pending: owner 2 preempted on its 16th owned cycle
    apply(1'b1, 4'b1100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int k = 1; k <= 16; k++)
      apply(1'b1, 4'b1100, 4'b0100, 4'b0000, 4'b0100, 1'b1, (k > 1), 1'b0,
            (k == 16) ? 4'b0100 : 4'b0000);
    apply(1'b1, 4'b1100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b1100, 4'b0100, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    // ptr=3: req[0] dropped on the hold_cnt==15 cycle releases without preempt
    apply(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int j = 1; j <= 16; j++)
      apply(1'b1, (j == 16) ? 4'b0000 : 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1,
            1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
`else
    // no timeout: req[2] held 40 cycles keeps the grant throughout
    apply(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int k = 1; k <= 40; k++)
      apply(1'b1, 4'b0100, (k % 2 == 1) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0100, 1'b1,
            (k > 1) && ((k - 1) % 2 == 1), 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
`endif

    repeat (3) @(negedge clk);
    #1;
    done = 1'b1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL expired wait: %0d queued expectation(s) never compared", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule

// File: doc/block_arbiter.md
Name: block_arbiter

Overview:
- Shares one instance of the `block` test unit between NREQ requesters.
- Round-robin arbitration; one owner at a time; owner's in1/in2 muxed onto the unit, unit's out1/out2 broadcast back.
- Sits between requester agents and the `block` instance; sequences ownership, enforces a one-cycle handover gap, optionally preempts long holders.

Parameters:
- NREQ, 4, number of requesters (2..16).
- MAX_HOLD, 16, max consecutive owned cycles before preemption (timeout feature only; >=2).
- PTR_W, $clog2(NREQ), width of round-robin pointer / owner index (derived, do not override).

Ports:
- clk  in  1  main clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester ownership request, held high for whole transaction.
- req_in1  in  NREQ  per-requester in1 value.
- req_in2  in  NREQ  per-requester in2 value.
- gnt  out  NREQ  one-hot grant, registered.
- preempt  out  NREQ  one-cycle pulse to owner forcibly released by timeout.
- busy  out  1  high while any grant active.
- blk_in1  out  1  to block in1, registered.
- blk_in2  out  1  to block in2, registered.
- blk_out1  in  1  from block out1.
- blk_out2  in  1  from block out2.
- rsp_out1  out  1  blk_out1 passthrough (combinational); valid only to gnt holder.
- rsp_out2  out  1  blk_out2 passthrough (combinational).

Behaviour:
- Reset (reset=0, async): gnt=0, preempt=0, busy=0, blk_in1/2=0, ptr=0, hold_cnt=0, state=IDLE. Reset mid-ownership drops grant immediately.
- FSM states: IDLE, OWN, GAP.
- IDLE: when |req, pick first asserted req at or after ptr, wrapping NREQ-1 -> 0. Next cycle: gnt[w]=1, busy=1, state=OWN. Latency req->gnt = 1 cycle.
- OWN:
  - blk_in1/2 <= req_in1/2[w] every cycle, so block sees data 1 cycle after requester drives it.
  - hold_cnt increments from 0.
  - req[w]=0 -> GAP (normal release).
  - Timeout, feature enabled: hold_cnt==MAX_HOLD-1 with req[w] still 1 -> GAP, preempt[w]=1 for that one cycle.
  - Simultaneous req drop and timeout: normal release, no preempt.
- GAP (exactly 1 cycle):
  - gnt=0, blk_in1/2=0, busy=0, hold_cnt=0.
  - ptr <= (w+1) mod NREQ.
  - Arbitrate as in IDLE using the new ptr: any req -> OWN next cycle, else IDLE.
  - Minimum owner-to-owner handover: 1 dead cycle.
- Fairness: sole requester re-wins after GAP. With all NREQ requesting, each is served once per NREQ ownerships.
- Preempted owner must drop req for at least 1 cycle before re-requesting. If it keeps req high, it re-enters round-robin order normally.
- Non-owner req_in1/2 ignored. gnt always one-hot or zero (checked by assertion).

Optional Feature:
- Macro: BLOCK_ARBITER_TIMEOUT_EN.
- Defined: hold_cnt compared with MAX_HOLD; preemption as above.
- Undefined: no preemption; owner holds indefinitely; preempt tied 0; hold_cnt logic removed.

Decomposition:
- Shared package block_arb_pkg holds:
  - state enum (IDLE, OWN, GAP);
  - default NREQ / MAX_HOLD constants;
  - function rr_pick(req, ptr) returning winner index and valid.
- One sub-module natural: block_arb_rr, combinational round-robin picker (req, ptr -> idx, valid), reusable by other shared-resource arbiters.

Test Plan:
- Reset: assert reset=0 while gnt[2]=1 -> gnt=0, blk_in1/2=0, busy=0 same cycle. After release, req=4'b0100 -> gnt=4'b0100 one cycle later.
- Single requester: req[1]=1 for 5 cycles with req_in1[1] toggling -> gnt[1] at cycle+1, blk_in1 follows with 1-cycle lag. Drop req -> 1 GAP cycle with gnt=0, ptr=2.
- Round-robin: req=4'b1111 held, each owner holds 3 cycles -> grant order 0,1,2,3,0, each separated by exactly 1 GAP cycle.
- Wrap: ptr=3, req=4'b0001 -> gnt[0]. Then ptr=0 at next GAP is ignored, ptr becomes 1.
- Timeout (macro on, MAX_HOLD=16): req[2] held 20 cycles -> gnt[2] high exactly 16 cycles, preempt[2] pulse on 16th owned cycle. With req[3] pending, gnt[3] after 1 GAP cycle.
- Timeout boundary: req[0] dropped on the cycle hold_cnt==15 -> no preempt pulse. Macro off: req held 40 cycles -> gnt continuous, preempt stays 0.
